// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch sequencer.
package pc_seq_pkg;

    // Sequencer states; StTrap is only reachable when the misalign trap is built in.
    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StIssue,
        StTrap
    } pc_state_e;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
    localparam logic [31:0] DefaultPcStep  = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: req/addr from the sequencer, ack from memory.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, issues one req/ack fetch per instruction and
// applies sequential advance, redirect and stall. All outputs are registered.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> TRAP state).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DefaultPcStep)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    pc_sequencer_if.master     imem,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               trap
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              trap_q, trap_d;

    logic [ADDR_W-1:0] tgt_load;
    logic              tgt_bad;
    logic              ack_seen;

    // Redirect target as it will be loaded, and whether it must trap.
    always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
        tgt_load = redirect_target;
        tgt_bad  = |redirect_target[1:0];
`else
        tgt_load = redirect_target & ~ADDR_W'(3);
        tgt_bad  = 1'b0;
`endif
    end

    // An ack only counts while a request is actually outstanding.
    assign ack_seen = req_q & imem.imem_ack;

    // Next-state, next-PC and registered-output decisions.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        req_d     = 1'b0;
        valid_d   = 1'b0;
        trap_d    = trap_q;

        case (state_q)
            StBoot: begin
                state_d = StFetch;
                req_d   = 1'b1;
            end

            StFetch: begin
                req_d = 1'b1;
                if (redirect_valid && tgt_bad) begin
                    state_d = StTrap;
                    pc_d    = tgt_load;
                    pend_d  = 1'b0;
                    req_d   = 1'b0;
                    trap_d  = 1'b1;
                end else if (redirect_valid) begin
                    if (ack_seen) begin
                        // Redirect beats the ack: drop response, refetch after a gap cycle.
                        pc_d   = tgt_load;
                        pend_d = 1'b0;
                        req_d  = 1'b0;
                    end else begin
                        // Fetch still in flight; remember the newest target.
                        pend_pc_d = tgt_load;
                        pend_d    = 1'b1;
                    end
                end else if (ack_seen) begin
                    if (pend_q) begin
                        pc_d   = pend_pc_q;
                        pend_d = 1'b0;
                        req_d  = 1'b0;
                    end else begin
                        state_d = StIssue;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                    end
                end
            end

            StIssue: begin
                if (redirect_valid && tgt_bad) begin
                    state_d = StTrap;
                    pc_d    = tgt_load;
                    trap_d  = 1'b1;
                end else if (redirect_valid) begin
                    state_d = StFetch;
                    pc_d    = tgt_load;
                    req_d   = 1'b1;
                end else if (!stall) begin
                    state_d = StFetch;
                    pc_d    = pc_q + PC_STEP;
                    req_d   = 1'b1;
                end
            end

`ifdef PC_MISALIGN_TRAP_EN
            StTrap: begin
                trap_d = 1'b1;
            end
`endif

            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and output registers; reset aborts any fetch immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            trap_q    <= trap_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = valid_q;
    assign pc_out         = pc_q;
    assign trap           = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default-reset instance plus a wrap-around instance.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Main instance (RESET_PC = 0)
    logic        rst, stall, redir_v;
    logic [31:0] redir_t;
    logic        valid;
    logic [31:0] pc;
    logic        trap;
    pc_sequencer_if #(.ADDR_W(32)) bus_m ();

    pc_sequencer #(.ADDR_W(32)) uut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redir_v),
        .redirect_target (redir_t),
        .imem            (bus_m),
        .instr_valid     (valid),
        .pc_out          (pc),
        .trap            (trap)
    );

    // Wrap instance (RESET_PC = 0xFFFFFFFC)
    logic        rst_w;
    logic        zero_b = 1'b0;
    logic [31:0] zero_w = 32'h0;
    logic        valid_w;
    logic [31:0] pc_w;
    logic        trap_w;
    pc_sequencer_if #(.ADDR_W(32)) bus_w ();

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) uut_w (
        .clk             (clk),
        .rst             (rst_w),
        .stall           (zero_b),
        .redirect_valid  (zero_b),
        .redirect_target (zero_w),
        .imem            (bus_w),
        .instr_valid     (valid_w),
        .pc_out          (pc_w),
        .trap            (trap_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir_v = 1'b0; redir_t = 32'h0;
        rst_w = 1'b1;
        bus_m.imem_ack = 1'b0;
        bus_w.imem_ack = 1'b0;
        step();
        step();

        // Reset state
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_req", 32'(bus_m.imem_req), 32'h0);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_trap", 32'(trap), 32'h0);
        rst = 1'b0;
        step();
        check_eq("boot_to_fetch_req", 32'(bus_m.imem_req), 32'h1);

        // 1: sequential fetch, ack one cycle after req, 3-cycle cadence
        for (int i = 0; i < 3; i++) begin
            check_eq("seq_addr", bus_m.imem_addr, 32'(i * 4));
            step();
            check_eq("seq_wait_valid", 32'(valid), 32'h0);
            bus_m.imem_ack = 1'b1;
            step();
            bus_m.imem_ack = 1'b0;
            check_eq("seq_valid", 32'(valid), 32'h1);
            check_eq("seq_pc", pc, 32'(i * 4));
            if (i == 2) break;
            step();
            check_eq("seq_req", 32'(bus_m.imem_req), 32'h1);
        end

        // 2: stall in ISSUE at 0x8; stray acks while idle are ignored
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_m.imem_ack = (i >= 2);
            step();
            check_eq("stall_pc", pc, 32'h8);
            check_eq("stall_req", 32'(bus_m.imem_req), 32'h0);
            check_eq("stall_valid", 32'(valid), 32'h0);
        end
        bus_m.imem_ack = 1'b0;
        stall = 1'b0;
        step();
        check_eq("unstall_pc", pc, 32'hC);
        check_eq("unstall_req", 32'(bus_m.imem_req), 32'h1);

        // Finish 0xC and reach FETCH at 0x10
        bus_m.imem_ack = 1'b1;
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("c_valid", 32'(valid), 32'h1);
        step();
        check_eq("fetch10_addr", bus_m.imem_addr, 32'h10);

        // 3: redirect while waiting for 0x10, ack two cycles later
        redir_v = 1'b1; redir_t = 32'h100;
        step();
        redir_v = 1'b0;
        check_eq("pend_addr_hold", bus_m.imem_addr, 32'h10);
        step();
        bus_m.imem_ack = 1'b1;
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("drop_valid", 32'(valid), 32'h0);
        check_eq("drop_gap_req", 32'(bus_m.imem_req), 32'h0);
        check_eq("drop_pc", pc, 32'h100);
        step();
        check_eq("refetch_req", 32'(bus_m.imem_req), 32'h1);
        check_eq("refetch_addr", bus_m.imem_addr, 32'h100);
        bus_m.imem_ack = 1'b1;
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("r100_valid", 32'(valid), 32'h1);
        check_eq("r100_pc", pc, 32'h100);
        step();
        check_eq("after100_addr", bus_m.imem_addr, 32'h104);

        // 4: redirect and ack in the same cycle; then redirect+stall in ISSUE
        redir_v = 1'b1; redir_t = 32'h40; bus_m.imem_ack = 1'b1;
        step();
        redir_v = 1'b0; bus_m.imem_ack = 1'b0;
        check_eq("race_valid", 32'(valid), 32'h0);
        check_eq("race_pc", pc, 32'h40);
        step();
        check_eq("race_refetch", bus_m.imem_addr, 32'h40);
        bus_m.imem_ack = 1'b1;
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("r40_valid", 32'(valid), 32'h1);
        stall = 1'b1; redir_v = 1'b1; redir_t = 32'h80;
        step();
        stall = 1'b0; redir_v = 1'b0;
        check_eq("redir_over_stall_pc", pc, 32'h80);
        check_eq("redir_over_stall_req", 32'(bus_m.imem_req), 32'h1);

        // 6: misaligned redirect 0x102 from ISSUE
        bus_m.imem_ack = 1'b1;
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("r80_pc", pc, 32'h80);
        redir_v = 1'b1; redir_t = 32'h102;
        step();
        redir_v = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("trap_flag", 32'(trap), 32'h1);
        check_eq("trap_pc", pc, 32'h102);
        check_eq("trap_req", 32'(bus_m.imem_req), 32'h0);
        bus_m.imem_ack = 1'b1;
        step();
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("trap_hold_flag", 32'(trap), 32'h1);
        check_eq("trap_hold_pc", pc, 32'h102);
        check_eq("trap_hold_valid", 32'(valid), 32'h0);
`else
        check_eq("align_trap", 32'(trap), 32'h0);
        check_eq("align_pc", pc, 32'h100);
        check_eq("align_req", 32'(bus_m.imem_req), 32'h1);
        bus_m.imem_ack = 1'b1;
        step();
        bus_m.imem_ack = 1'b0;
        check_eq("align_valid", 32'(valid), 32'h1);
        step();
        check_eq("align_next", pc, 32'h104);
`endif

        // 5: wrap-around instance
        rst_w = 1'b0;
        check_eq("w_rst_pc", pc_w, 32'hFFFF_FFFC);
        step();
        check_eq("w_req", 32'(bus_w.imem_req), 32'h1);
        bus_w.imem_ack = 1'b1;
        step();
        bus_w.imem_ack = 1'b0;
        check_eq("w_valid", 32'(valid_w), 32'h1);
        step();
        check_eq("w_wrap_pc", pc_w, 32'h0);
        check_eq("w_wrap_trap", 32'(trap_w), 32'h0);
        // Async reset mid-FETCH
        #2;
        rst_w = 1'b1;
        #1;
        check_eq("w_abort_req", 32'(bus_w.imem_req), 32'h0);
        check_eq("w_abort_pc", pc_w, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        bus_w.imem_ack = 1'b1;
        rst_w = 1'b0;
        step();
        bus_w.imem_ack = 1'b0;
        check_eq("w_late_ack_valid", 32'(valid_w), 32'h0);
        check_eq("w_restart_req", 32'(bus_w.imem_req), 32'h1);
        check_eq("w_restart_addr", bus_w.imem_addr, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
